dispatcher: RTL and testbench
=============================

Name: dispatcher

Overview:
- Upstream end of the dispatcher-to-reservation-station interface.
- Accepts one decoded instruction per cycle and resolves its source operands against the register file, the ROB and both CDB buses.
- Allocates the ROB entry and renames rd, then issues a one-cycle enable plus operand bundle to either the reservation station or the load/store buffer.
- Holds a single instruction in a registered buffer while the downstream unit or the ROB is full, snooping the CDBs while it waits.

Parameters:
- DATA_WIDTH, 32, width of operand, imm and pc.
- ROB_ID_WIDTH, 4, tag width; tag 0 = "no dependency", valid ROB ids are 1..15.
- OPENUM_WIDTH, 6, operation enum width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  misprediction flush.
- dec_valid  in  1  decoder presents an instruction.
- dec_ready  out  1  dispatcher can accept this cycle.
- dec_openum  in  OPENUM_WIDTH  operation.
- dec_is_ls  in  1  1 = route to LSB, 0 = route to RS.
- dec_rd, dec_rs1, dec_rs2  in  5 each  register indices.
- dec_imm, dec_pc  in  DATA_WIDTH  immediate and pc.
- rf_rs1_q, rf_rs2_q  out  5 each  register-file read indices (combinational from dec_rs1/dec_rs2).
- rf_q1, rf_q2  in  ROB_ID_WIDTH  rename tags; 0 = value valid.
- rf_v1, rf_v2  in  DATA_WIDTH  register values.
- rob_q1_ready, rob_q2_ready  in  1  ROB already holds the result for rf_q1 / rf_q2.
- rob_v1, rob_v2  in  DATA_WIDTH  those ROB results.
- rob_full  in  1  no ROB entry free.
- rob_free_id  in  ROB_ID_WIDTH  next ROB id to be allocated.
- rob_alloc_en  out  1  allocate the ROB entry.
- rob_rd, rob_pc, rob_openum  out  ROB entry contents.
- rename_en  out  1  rename request to the register file.
- rename_rd  out  5  renamed register.
- rename_id  out  ROB_ID_WIDTH  new tag for rename_rd.
- alu_cdb_valid, alu_cdb_id, alu_cdb_value  in  ALU result broadcast.
- lsb_cdb_valid, lsb_cdb_id, lsb_cdb_value  in  LSB result broadcast.
- rs_full, lsb_full  in  1  downstream unit has no free slot.
- rs_enable, lsb_enable  out  1  one-cycle issue strobes.
- openum_out, Q1_out, Q2_out, V1_out, V2_out, pc_out, imm_out, rob_id_out  out  shared issue bus, all registered.

Behaviour:
- States:
  - EMPTY: buffer invalid, dec_ready = 1.
  - HOLD: buffer valid, dec_ready = 0.
- Capture (EMPTY, dec_valid, rdy, no flush): latch the instruction. Per operand:
  - If rf_q == 0, take Q = 0 and V = rf_v.
  - Else if rob_q_ready, take Q = 0 and V = rob_v.
  - Else if a CDB is valid with id == rf_q, take Q = 0 and V = cdb_value (ALU bus checked before LSB).
  - Else Q = rf_q, V = 0.
  - Go to HOLD.
- HOLD snoop: every cycle, for each operand with Q != 0, a matching CDB broadcast sets Q = 0 and V = value. Q1 and Q2 resolve independently, and both may resolve in the same cycle.
- Issue (HOLD, !rob_full, target not full, where target = lsb if is_ls else rs): in the same cycle, drive the registered outputs for the next edge:
  - target enable = 1;
  - issue bus = buffer contents, with that cycle's CDB snoop applied;
  - rob_id_out = rob_free_id;
  - rob_alloc_en = 1;
  - rename_en = 1 only if rd != 0.
  - Go to EMPTY.
  - Operands need not be ready to issue; the RS/LSB waits on tags.
- Latency: accept at edge T, strobes high during cycle T+1 at the earliest. Back-to-back throughput is one instruction per 2 cycles.
- Strobes (rs_enable, lsb_enable, rob_alloc_en, rename_en) are high for exactly one cycle per instruction. rs_enable and lsb_enable are never high together.
- Full: while the target or ROB is full, stay in HOLD and keep snooping; issue on the first cycle both have space.
- flush: highest priority after rst. Buffer invalid, state EMPTY, all strobes 0 on the next cycle, a concurrent capture is discarded, an issue in progress is suppressed.
- rdy = 0: all registers hold; strobes are forced to 0 during that cycle.
- Reset: state EMPTY, all strobes 0, all issue-bus outputs 0, dec_ready = 1 after reset.

Optional Feature:
- Macro DISPATCH_STALL_CNT_EN.
- When defined: adds output stall_cycles, 32 bits. It increments on each rdy cycle spent in HOLD without issuing, wraps at 2^32, is cleared by rst and is not cleared by flush.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- rf_q1 = 0, rf_v1 = 5; rf_q2 = 0, rf_v2 = 7; dec_is_ls = 0; rob_free_id = 3 -> next cycle rs_enable = 1, V1 = 5, V2 = 7, Q1 = Q2 = 0, rob_id_out = 3, rename_en = 1 for rd = 4.
- rf_q1 = 2, rob_q1_ready = 0; rs_full held for 3 cycles; alu_cdb (id 2, value 0x99) arrives in cycle 2 -> issue in the cycle after rs_full drops, with Q1 = 0, V1 = 0x99, exactly one rs_enable pulse.
- Capture with rf_q1 = 6 and lsb_cdb_valid, id 6, value 0xAB in the same cycle -> Q1_out = 0, V1_out = 0xAB.
- dec_is_ls = 1 with rob_full = 1 for 2 cycles -> no strobes, dec_ready = 0; then lsb_enable = 1, rob_alloc_en = 1; rd = 0 -> rename_en = 0.
- Instruction held, flush asserted together with dec_valid -> no enable issued, state EMPTY, dec_ready = 1 on the next cycle; with DISPATCH_STALL_CNT_EN, the stall count before the flush is retained.

Source files
------------

// File: rtl/dispatcher_if.sv
// Decoder-to-dispatcher handshake: one decoded instruction per valid/ready beat.
// The decoder drives through the master modport; the dispatcher uses the slave modport.
interface dispatcher_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPENUM_WIDTH = 6
);
  logic                    valid;
  logic                    ready;
  logic [OPENUM_WIDTH-1:0] openum;
  logic                    is_ls;
  logic [4:0]              rd;
  logic [4:0]              rs1;
  logic [4:0]              rs2;
  logic [DATA_WIDTH-1:0]   imm;
  logic [DATA_WIDTH-1:0]   pc;

  modport master (output valid, openum, is_ls, rd, rs1, rs2, imm, pc, input ready);
  modport slave  (input valid, openum, is_ls, rd, rs1, rs2, imm, pc, output ready);
endinterface

// File: rtl/dispatcher.sv
// Dispatcher: captures one decoded instruction, resolves its operands against
// RF / ROB / both CDBs, holds it while downstream or the ROB is full (snooping
// the CDBs), then issues a registered operand bundle to the RS or the LSB.
// Optional macro DISPATCH_STALL_CNT_EN adds the stall_cycles counter output.
module dispatcher #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int OPENUM_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  dispatcher_if.slave             dec,
  output logic [4:0]              rf_rs1_q,
  output logic [4:0]              rf_rs2_q,
  input  logic [ROB_ID_WIDTH-1:0] rf_q1,
  input  logic [ROB_ID_WIDTH-1:0] rf_q2,
  input  logic [DATA_WIDTH-1:0]   rf_v1,
  input  logic [DATA_WIDTH-1:0]   rf_v2,
  input  logic                    rob_q1_ready,
  input  logic                    rob_q2_ready,
  input  logic [DATA_WIDTH-1:0]   rob_v1,
  input  logic [DATA_WIDTH-1:0]   rob_v2,
  input  logic                    rob_full,
  input  logic [ROB_ID_WIDTH-1:0] rob_free_id,
  output logic                    rob_alloc_en,
  output logic [4:0]              rob_rd,
  output logic [DATA_WIDTH-1:0]   rob_pc,
  output logic [OPENUM_WIDTH-1:0] rob_openum,
  output logic                    rename_en,
  output logic [4:0]              rename_rd,
  output logic [ROB_ID_WIDTH-1:0] rename_id,
  input  logic                    alu_cdb_valid,
  input  logic [ROB_ID_WIDTH-1:0] alu_cdb_id,
  input  logic [DATA_WIDTH-1:0]   alu_cdb_value,
  input  logic                    lsb_cdb_valid,
  input  logic [ROB_ID_WIDTH-1:0] lsb_cdb_id,
  input  logic [DATA_WIDTH-1:0]   lsb_cdb_value,
  input  logic                    rs_full,
  input  logic                    lsb_full,
  output logic                    rs_enable,
  output logic                    lsb_enable,
  output logic [OPENUM_WIDTH-1:0] openum_out,
  output logic [ROB_ID_WIDTH-1:0] Q1_out,
  output logic [ROB_ID_WIDTH-1:0] Q2_out,
  output logic [DATA_WIDTH-1:0]   V1_out,
  output logic [DATA_WIDTH-1:0]   V2_out,
  output logic [DATA_WIDTH-1:0]   pc_out,
  output logic [DATA_WIDTH-1:0]   imm_out,
  output logic [ROB_ID_WIDTH-1:0] rob_id_out
`ifdef DISPATCH_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);
  typedef enum logic {EMPTY, HOLD} state_t;

  state_t state_reg, state_next;
  logic   capture_go, issue_go, can_issue;

  // Held instruction; operand index 0 is rs1, index 1 is rs2.
  logic [OPENUM_WIDTH-1:0]      openum_reg;
  logic                         is_ls_reg;
  logic [4:0]                   rd_reg;
  logic [DATA_WIDTH-1:0]        imm_reg, pc_reg;
  logic [1:0][ROB_ID_WIDTH-1:0] buf_q_reg, cap_q, snp_q, rf_q;
  logic [1:0][DATA_WIDTH-1:0]   buf_v_reg, cap_v, snp_v, rf_v, rob_v;
  logic [1:0]                   rob_ready;

  // Issue-side registers.
  logic rs_en_reg, lsb_en_reg, alloc_reg, rename_reg;
  logic [OPENUM_WIDTH-1:0] openum_out_reg, rob_openum_reg;
  logic [ROB_ID_WIDTH-1:0] q1_out_reg, q2_out_reg, rob_id_out_reg, rename_id_reg;
  logic [DATA_WIDTH-1:0]   v1_out_reg, v2_out_reg, pc_out_reg, imm_out_reg, rob_pc_reg;
  logic [4:0]              rob_rd_reg, rename_rd_reg;

  assign rf_rs1_q  = dec.rs1;
  assign rf_rs2_q  = dec.rs2;
  assign dec.ready = (state_reg == EMPTY);

  assign rf_q      = {rf_q2, rf_q1};
  assign rf_v      = {rf_v2, rf_v1};
  assign rob_v     = {rob_v2, rob_v1};
  assign rob_ready = {rob_q2_ready, rob_q1_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic [ROB_ID_WIDTH-1:0] cq, sq;
      logic [DATA_WIDTH-1:0]   cv, sv;

      // Capture-time resolution: RF value, then ROB result, then ALU CDB, then LSB CDB.
      always_comb begin
        cq = rf_q[gi];
        cv = '0;
        if (rf_q[gi] == '0) begin
          cv = rf_v[gi];
        end else if (rob_ready[gi]) begin
          cq = '0;
          cv = rob_v[gi];
        end else if (alu_cdb_valid && alu_cdb_id == rf_q[gi]) begin
          cq = '0;
          cv = alu_cdb_value;
        end else if (lsb_cdb_valid && lsb_cdb_id == rf_q[gi]) begin
          cq = '0;
          cv = lsb_cdb_value;
        end
      end

      // Snoop of the held operand; also feeds the issue bus in the issuing cycle.
      always_comb begin
        sq = buf_q_reg[gi];
        sv = buf_v_reg[gi];
        if (buf_q_reg[gi] != '0) begin
          if (alu_cdb_valid && alu_cdb_id == buf_q_reg[gi]) begin
            sq = '0;
            sv = alu_cdb_value;
          end else if (lsb_cdb_valid && lsb_cdb_id == buf_q_reg[gi]) begin
            sq = '0;
            sv = lsb_cdb_value;
          end
        end
      end

      assign cap_q[gi] = cq;
      assign cap_v[gi] = cv;
      assign snp_q[gi] = sq;
      assign snp_v[gi] = sv;
    end
  endgenerate

  assign can_issue = (state_reg == HOLD) && !rob_full && !(is_ls_reg ? lsb_full : rs_full);

  // Next state plus the capture / issue decision for this cycle.
  always_comb begin
    state_next = state_reg;
    capture_go = 1'b0;
    issue_go   = 1'b0;
    if (rdy && !flush) begin
      case (state_reg)
        EMPTY: if (dec.valid) begin
          capture_go = 1'b1;
          state_next = HOLD;
        end
        HOLD: if (can_issue) begin
          issue_go   = 1'b1;
          state_next = EMPTY;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State register and instruction buffer (capture, then snoop while held).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= EMPTY;
      openum_reg <= '0;
      is_ls_reg  <= 1'b0;
      rd_reg     <= '0;
      imm_reg    <= '0;
      pc_reg     <= '0;
      buf_q_reg  <= '0;
      buf_v_reg  <= '0;
    end else if (flush) begin
      state_reg <= EMPTY;
    end else if (rdy) begin
      state_reg <= state_next;
      if (capture_go) begin
        openum_reg <= dec.openum;
        is_ls_reg  <= dec.is_ls;
        rd_reg     <= dec.rd;
        imm_reg    <= dec.imm;
        pc_reg     <= dec.pc;
        buf_q_reg  <= cap_q;
        buf_v_reg  <= cap_v;
      end else if (state_reg == HOLD) begin
        buf_q_reg <= snp_q;
        buf_v_reg <= snp_v;
      end
    end
  end

  // Issue strobes and registered issue bus; strobes last one cycle per issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_en_reg      <= 1'b0;
      lsb_en_reg     <= 1'b0;
      alloc_reg      <= 1'b0;
      rename_reg     <= 1'b0;
      openum_out_reg <= '0;
      q1_out_reg     <= '0;
      q2_out_reg     <= '0;
      v1_out_reg     <= '0;
      v2_out_reg     <= '0;
      pc_out_reg     <= '0;
      imm_out_reg    <= '0;
      rob_id_out_reg <= '0;
      rob_rd_reg     <= '0;
      rob_pc_reg     <= '0;
      rob_openum_reg <= '0;
      rename_rd_reg  <= '0;
      rename_id_reg  <= '0;
    end else if (flush) begin
      rs_en_reg  <= 1'b0;
      lsb_en_reg <= 1'b0;
      alloc_reg  <= 1'b0;
      rename_reg <= 1'b0;
    end else if (rdy) begin
      rs_en_reg  <= issue_go && !is_ls_reg;
      lsb_en_reg <= issue_go && is_ls_reg;
      alloc_reg  <= issue_go;
      rename_reg <= issue_go && (rd_reg != 5'd0);
      if (issue_go) begin
        openum_out_reg <= openum_reg;
        q1_out_reg     <= snp_q[0];
        q2_out_reg     <= snp_q[1];
        v1_out_reg     <= snp_v[0];
        v2_out_reg     <= snp_v[1];
        pc_out_reg     <= pc_reg;
        imm_out_reg    <= imm_reg;
        rob_id_out_reg <= rob_free_id;
        rob_rd_reg     <= rd_reg;
        rob_pc_reg     <= pc_reg;
        rob_openum_reg <= openum_reg;
        rename_rd_reg  <= rd_reg;
        rename_id_reg  <= rob_free_id;
      end
    end
  end

  // A frozen (rdy low) cycle masks the strobes; the held register re-presents them afterwards.
  assign rs_enable    = rs_en_reg && rdy;
  assign lsb_enable   = lsb_en_reg && rdy;
  assign rob_alloc_en = alloc_reg && rdy;
  assign rename_en    = rename_reg && rdy;

  assign openum_out = openum_out_reg;
  assign Q1_out     = q1_out_reg;
  assign Q2_out     = q2_out_reg;
  assign V1_out     = v1_out_reg;
  assign V2_out     = v2_out_reg;
  assign pc_out     = pc_out_reg;
  assign imm_out    = imm_out_reg;
  assign rob_id_out = rob_id_out_reg;
  assign rob_rd     = rob_rd_reg;
  assign rob_pc     = rob_pc_reg;
  assign rob_openum = rob_openum_reg;
  assign rename_rd  = rename_rd_reg;
  assign rename_id  = rename_id_reg;

`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_reg;

  // Counts active cycles the held instruction is blocked by a full ROB or target.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (rdy && !flush && state_reg == HOLD && !can_issue) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
`endif
endmodule

// File: tb/tb_dispatcher.sv
// Self-checking bench for dispatcher: expected issue bundles are queued when an
// instruction is presented and compared against bundles seen on the strobes.
module tb_dispatcher;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int OW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  logic [4:0] rf_rs1_q, rf_rs2_q;
  logic [RW-1:0] rf_q1, rf_q2, rob_free_id, alu_cdb_id, lsb_cdb_id;
  logic [DW-1:0] rf_v1, rf_v2, rob_v1, rob_v2, alu_cdb_value, lsb_cdb_value;
  logic rob_q1_ready, rob_q2_ready, rob_full, alu_cdb_valid, lsb_cdb_valid, rs_full, lsb_full;
  logic rob_alloc_en, rename_en, rs_enable, lsb_enable;
  logic [4:0] rob_rd, rename_rd;
  logic [DW-1:0] rob_pc, V1_out, V2_out, pc_out, imm_out;
  logic [OW-1:0] rob_openum, openum_out;
  logic [RW-1:0] rename_id, Q1_out, Q2_out, rob_id_out;
`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  dispatcher_if #(.DATA_WIDTH(DW), .OPENUM_WIDTH(OW)) dec_bus ();

  dispatcher #(.DATA_WIDTH(DW), .ROB_ID_WIDTH(RW), .OPENUM_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .dec(dec_bus),
    .rf_rs1_q(rf_rs1_q), .rf_rs2_q(rf_rs2_q), .rf_q1(rf_q1), .rf_q2(rf_q2),
    .rf_v1(rf_v1), .rf_v2(rf_v2), .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
    .rob_v1(rob_v1), .rob_v2(rob_v2), .rob_full(rob_full), .rob_free_id(rob_free_id),
    .rob_alloc_en(rob_alloc_en), .rob_rd(rob_rd), .rob_pc(rob_pc), .rob_openum(rob_openum),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_id(rename_id),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_id(alu_cdb_id), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_id(lsb_cdb_id), .lsb_cdb_value(lsb_cdb_value),
    .rs_full(rs_full), .lsb_full(lsb_full), .rs_enable(rs_enable), .lsb_enable(lsb_enable),
    .openum_out(openum_out), .Q1_out(Q1_out), .Q2_out(Q2_out), .V1_out(V1_out), .V2_out(V2_out),
    .pc_out(pc_out), .imm_out(imm_out), .rob_id_out(rob_id_out)
`ifdef DISPATCH_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rs_en; logic lsb_en; logic alloc; logic ren;
    logic [OW-1:0] openum; logic [RW-1:0] q1; logic [RW-1:0] q2;
    logic [DW-1:0] v1; logic [DW-1:0] v2; logic [DW-1:0] pc; logic [DW-1:0] imm;
    logic [RW-1:0] rob_id; logic [4:0] rob_rd; logic [DW-1:0] rob_pc; logic [OW-1:0] rob_openum;
    logic [4:0] rename_rd; logic [RW-1:0] rename_id;
  } issue_t;

  issue_t exp_q[$];
  issue_t obs_q[$];
  int     obs_cyc[$];
  int     cycle = 0;
  int     checks = 0;
  int     errors = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic issue_t sample_bus();
    issue_t s;
    s = '{rs_enable, lsb_enable, rob_alloc_en, rename_en, openum_out, Q1_out, Q2_out,
          V1_out, V2_out, pc_out, imm_out, rob_id_out, rob_rd, rob_pc, rob_openum,
          rename_en ? rename_rd : 5'd0, rename_en ? rename_id : {RW{1'b0}}};
    return s;
  endfunction

  function automatic issue_t make_exp(input logic is_ls, input logic [4:0] rd, input logic [OW-1:0] op,
                                      input logic [RW-1:0] q1, input logic [RW-1:0] q2,
                                      input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                                      input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                                      input logic [RW-1:0] rob_id);
    issue_t e;
    logic ren;
    ren = (rd != 5'd0);
    e = '{!is_ls, is_ls, 1'b1, ren, op, q1, q2, v1, v2, pc, imm, rob_id, rd, pc, op,
          ren ? rd : 5'd0, ren ? rob_id : {RW{1'b0}}};
    return e;
  endfunction

  // Record every cycle with any strobe high; a stuck strobe shows up as an extra entry.
  always @(negedge clk) begin
    if (rs_enable || lsb_enable || rob_alloc_en || rename_en) begin
      obs_q.push_back(sample_bus());
      obs_cyc.push_back(cycle);
    end
  end

  task automatic idle();
    dec_bus.valid = 0; dec_bus.openum = '0; dec_bus.is_ls = 0; dec_bus.rd = '0;
    dec_bus.rs1 = '0; dec_bus.rs2 = '0; dec_bus.imm = '0; dec_bus.pc = '0;
    rdy = 1; flush = 0; rf_q1 = '0; rf_q2 = '0; rf_v1 = '0; rf_v2 = '0;
    rob_q1_ready = 0; rob_q2_ready = 0; rob_v1 = '0; rob_v2 = '0; rob_full = 0; rob_free_id = '0;
    alu_cdb_valid = 0; alu_cdb_id = '0; alu_cdb_value = '0;
    lsb_cdb_valid = 0; lsb_cdb_id = '0; lsb_cdb_value = '0;
    rs_full = 0; lsb_full = 0;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic present(input logic is_ls, input logic [4:0] rd, input logic [OW-1:0] op,
                         input logic [DW-1:0] pc, input logic [DW-1:0] imm);
    dec_bus.valid = 1; dec_bus.is_ls = is_ls; dec_bus.rd = rd; dec_bus.openum = op;
    dec_bus.pc = pc; dec_bus.imm = imm; dec_bus.rs1 = rd + 5'd1; dec_bus.rs2 = rd + 5'd2;
  endtask

  task automatic wait_obs(input int n);
    int g;
    g = 0;
    while (obs_q.size() < n && g < 30) begin
      @(negedge clk); #1;
      g++;
    end
  endtask

  task automatic test_reset();
    issue_t o;
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    o = sample_bus();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_bus_in_reset: got %h required 0", o); end
    rst = 0;
    @(negedge clk); #1;
    o = sample_bus();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_bus: got %h required 0", o); end
    checks++;
    if (dec_bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", dec_bus.ready); end
    $display("reset: dec_ready=%b rs_enable=%b lsb_enable=%b", dec_bus.ready, rs_enable, lsb_enable);
  endtask

  task automatic test_basic();
    issue_t o, e;
    int c, cap;
    @(posedge clk); #1;
    idle();
    present(0, 5'd4, 6'd12, 32'h100, 32'h10);
    rf_v1 = 32'd5; rf_v2 = 32'd7; rob_free_id = 4'd3;
    exp_q.push_back(make_exp(0, 5'd4, 6'd12, 0, 0, 32'd5, 32'd7, 32'h100, 32'h10, 4'd3));
    #1;
    checks++;
    if (rf_rs1_q !== 5'd5 || rf_rs2_q !== 5'd6) begin
      errors++; $display("FAIL basic_rf_index: got %0d/%0d required 5/6", rf_rs1_q, rf_rs2_q);
    end
    @(posedge clk); #1;
    cap = cycle; dec_bus.valid = 0;
    checks++;
    if (dec_bus.ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready: got %b required 0", dec_bus.ready); end
    wait_obs(1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL basic_count: got %0d issues required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); c = obs_cyc.pop_front(); e = exp_q.pop_front();
      $display("basic issue: rs=%b V1=%0d V2=%0d rob_id=%0d rename=%b", o.rs_en, o.v1, o.v2, o.rob_id, o.ren);
      checks++;
      if (o !== e) begin errors++; $display("FAIL basic_bundle: got %h required %h", o, e); end
      checks++;
      if (c != cap + 1) begin errors++; $display("FAIL basic_latency: got cycle %0d required %0d", c, cap + 1); end
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL basic_single_pulse: got %0d extra required 0", obs_q.size()); end
  endtask

  task automatic test_cdb_wait();
    issue_t o, e;
    int c, rel;
    @(posedge clk); #1;
    idle();
    present(0, 5'd5, 6'd3, 32'h200, 32'h20);
    rf_q1 = 4'd2; rf_q2 = 4'd0; rf_v2 = 32'h22; rs_full = 1; rob_free_id = 4'd4;
    exp_q.push_back(make_exp(0, 5'd5, 6'd3, 0, 0, 32'h99, 32'h22, 32'h200, 32'h20, 4'd4));
    @(posedge clk); #1;
    dec_bus.valid = 0; rf_q1 = '0;
    @(posedge clk); #1;
    alu_cdb_valid = 1; alu_cdb_id = 4'd2; alu_cdb_value = 32'h99;
    @(posedge clk); #1;
    alu_cdb_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL cdb_wait_early: got %0d issues required 0", obs_q.size()); end
    rs_full = 0; rel = cycle;
    wait_obs(1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL cdb_wait_count: got %0d issues required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); c = obs_cyc.pop_front(); e = exp_q.pop_front();
      $display("cdb_wait issue: rs=%b Q1=%0d V1=%h cycle=%0d", o.rs_en, o.q1, o.v1, c);
      checks++;
      if (o !== e) begin errors++; $display("FAIL cdb_wait_bundle: got %h required %h", o, e); end
      checks++;
      if (c != rel + 1) begin errors++; $display("FAIL cdb_wait_timing: got cycle %0d required %0d", c, rel + 1); end
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL cdb_wait_single_pulse: got %0d extra required 0", obs_q.size()); end
  endtask

  task automatic test_capture_cdb();
    issue_t o, e;
    @(posedge clk); #1;
    idle();
    present(0, 5'd6, 6'd9, 32'h300, 32'h30);
    rf_q1 = 4'd6; rf_v1 = 32'hDEAD; rf_q2 = 4'd9; rob_free_id = 4'd5;
    lsb_cdb_valid = 1; lsb_cdb_id = 4'd6; lsb_cdb_value = 32'hAB;
    alu_cdb_valid = 1; alu_cdb_id = 4'd7; alu_cdb_value = 32'h77;
    exp_q.push_back(make_exp(0, 5'd6, 6'd9, 0, 0, 32'hAB, 32'h1234, 32'h300, 32'h30, 4'd5));
    @(posedge clk); #1;
    dec_bus.valid = 0; lsb_cdb_valid = 0;
    alu_cdb_id = 4'd9; alu_cdb_value = 32'h1234;
    @(posedge clk); #1;
    alu_cdb_valid = 0;
    wait_obs(1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL capture_cdb_count: got %0d issues required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); void'(obs_cyc.pop_front()); e = exp_q.pop_front();
      $display("capture_cdb issue: Q1=%0d V1=%h Q2=%0d V2=%h", o.q1, o.v1, o.q2, o.v2);
      checks++;
      if (o !== e) begin errors++; $display("FAIL capture_cdb_bundle: got %h required %h", o, e); end
    end
  endtask

  task automatic test_lsb_rob_full();
    issue_t o, e;
    int c, rel;
    @(posedge clk); #1;
    idle();
    present(1, 5'd0, 6'd40, 32'h400, 32'h40);
    rf_q1 = 4'd3; rob_q1_ready = 1; rob_v1 = 32'h55; rf_q2 = 4'd11;
    rob_full = 1; rs_full = 1; rob_free_id = 4'd9;
    exp_q.push_back(make_exp(1, 5'd0, 6'd40, 0, 4'd11, 32'h55, 0, 32'h400, 32'h40, 4'd9));
    @(posedge clk); #1;
    dec_bus.valid = 0; rob_q1_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (dec_bus.ready !== 1'b0 || obs_q.size() != 0) begin
        errors++; $display("FAIL rob_full_stall: got ready=%b issues=%0d required ready=0 issues=0", dec_bus.ready, obs_q.size());
      end
    end
    @(posedge clk); #1;
    rob_full = 0; rel = cycle;
    wait_obs(1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL lsb_count: got %0d issues required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); c = obs_cyc.pop_front(); e = exp_q.pop_front();
      $display("lsb issue: lsb=%b rs=%b alloc=%b rename=%b Q2=%0d", o.lsb_en, o.rs_en, o.alloc, o.ren, o.q2);
      checks++;
      if (o !== e) begin errors++; $display("FAIL lsb_bundle: got %h required %h", o, e); end
      checks++;
      if (c != rel + 1) begin errors++; $display("FAIL lsb_timing: got cycle %0d required %0d", c, rel + 1); end
    end
    checks++;
    if (dec_bus.ready !== 1'b1) begin errors++; $display("FAIL lsb_ready_after: got %b required 1", dec_bus.ready); end
    rs_full = 0;
  endtask

  task automatic test_flush();
`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0] stall_before;
`endif
    @(posedge clk); #1;
    idle();
    present(0, 5'd7, 6'd1, 32'h500, 32'h50);
    rs_full = 1; rob_free_id = 4'd6;
    @(posedge clk); #1;
    dec_bus.valid = 0;
    @(posedge clk); #1;
`ifdef DISPATCH_STALL_CNT_EN
    stall_before = stall_cycles;
    checks++;
    if (stall_before !== 32'd1) begin errors++; $display("FAIL stall_count: got %0d required 1", stall_before); end
`endif
    flush = 1; rs_full = 0;
    present(0, 5'd8, 6'd2, 32'h600, 32'h60);
    @(posedge clk); #1;
    flush = 0; dec_bus.valid = 0;
    checks++;
    if (dec_bus.ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b required 1", dec_bus.ready); end
`ifdef DISPATCH_STALL_CNT_EN
    checks++;
    if (stall_cycles !== stall_before) begin
      errors++; $display("FAIL flush_stall_kept: got %0d required %0d", stall_cycles, stall_before);
    end
`endif
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL flush_no_issue: got %0d issues required 0", obs_q.size()); end
    $display("flush: dec_ready=%b issues=%0d", dec_bus.ready, obs_q.size());
  endtask

  task automatic test_rdy_freeze();
    issue_t o, e;
    int c, cap;
    @(posedge clk); #1;
    idle();
    present(0, 5'd9, 6'd5, 32'h700, 32'h70);
    rf_v1 = 32'h11; rf_v2 = 32'h12; rob_free_id = 4'd2; rdy = 0;
    exp_q.push_back(make_exp(0, 5'd9, 6'd5, 0, 0, 32'h11, 32'h12, 32'h700, 32'h70, 4'd2));
    @(posedge clk); #1;
    checks++;
    if (dec_bus.ready !== 1'b1) begin errors++; $display("FAIL rdy_no_capture: got ready=%b required 1", dec_bus.ready); end
    rdy = 1;
    @(posedge clk); #1;
    cap = cycle; dec_bus.valid = 0; rdy = 0;
    @(posedge clk); #1;
    rdy = 1;
    wait_obs(1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL rdy_count: got %0d issues required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); c = obs_cyc.pop_front(); e = exp_q.pop_front();
      $display("rdy issue: V1=%h V2=%h cycle=%0d", o.v1, o.v2, c);
      checks++;
      if (o !== e) begin errors++; $display("FAIL rdy_bundle: got %h required %h", o, e); end
      checks++;
      if (c != cap + 2) begin errors++; $display("FAIL rdy_timing: got cycle %0d required %0d", c, cap + 2); end
    end
  endtask

  task automatic test_back_to_back();
    issue_t o, e;
    int c[3];
    int g;
    @(posedge clk); #1;
    idle();
    rob_free_id = 4'd10;
    for (int k = 0; k < 3; k++) begin
      present(0, 5'(k + 1), 6'(k + 20), 32'(32'h800 + k * 4), 32'(k));
      rf_v1 = 32'(k * 3 + 1); rf_v2 = 32'(k * 3 + 2);
      g = 0;
      @(negedge clk);
      while (!dec_bus.ready && g < 10) begin
        @(negedge clk);
        g++;
      end
      checks++;
      if (dec_bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", dec_bus.ready); end
      exp_q.push_back(make_exp(0, 5'(k + 1), 6'(k + 20), 0, 0, 32'(k * 3 + 1), 32'(k * 3 + 2),
                               32'(32'h800 + k * 4), 32'(k), 4'd10));
      @(posedge clk); #1;
    end
    dec_bus.valid = 0;
    wait_obs(3);
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d issues required 3", obs_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        o = obs_q.pop_front(); c[k] = obs_cyc.pop_front(); e = exp_q.pop_front();
        $display("b2b issue %0d: rd=%0d V1=%0d V2=%0d cycle=%0d", k, o.rob_rd, o.v1, o.v2, c[k]);
        checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_bundle_%0d: got %h required %h", k, o, e); end
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (c[k] - c[k-1] != 2) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d required 2", k, c[k] - c[k-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wait();
    test_capture_cdb();
    test_lsb_rob_full();
    test_flush();
    test_rdy_freeze();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
